// File: rtl/mario_pkg.sv
// Shared types and parameter defaults for the small-Mario animation controller.
package mario_pkg;
    localparam int SPRITE_W_DEF    = 24;
    localparam int SPRITE_H_DEF    = 32;
    localparam int WALK_PERIOD_DEF = 6;

    // Encoding doubles as the sprite ROM frame index.
    typedef enum logic [2:0] {
        ST_STAND = 3'd0,
        ST_WALK1 = 3'd1,
        ST_WALK2 = 3'd2,
        ST_WALK3 = 3'd3,
        ST_JUMP  = 3'd4
    } anim_state_e;
endpackage

// File: rtl/sprite_addr_gen.sv
// Stage 1: sprite-relative address and in-box test, registered with the frame tag.
module sprite_addr_gen
    import mario_pkg::*;
#(
    parameter int SPRITE_W = SPRITE_W_DEF,
    parameter int SPRITE_H = SPRITE_H_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] MarioX,
    input  logic [9:0] MarioY,
    input  logic       facing_left,
    input  logic [2:0] state_i,
    output logic [9:0] addr_o,
    output logic       inbox_o,
    output logic [2:0] state_o
);
    logic [9:0] dx, dy, col, addr_d, addr_q;
    logic       inbox_d, inbox_q;
    logic [2:0] state_q;

    // Wrapping subtraction puts pixels left of / above the sprite far out of range.
    always_comb begin
        dx      = DrawX - MarioX;
        dy      = DrawY - MarioY;
        inbox_d = (dx < 10'(SPRITE_W)) && (dy < 10'(SPRITE_H));
        col     = facing_left ? (10'(SPRITE_W - 1) - dx) : dx;
        addr_d  = inbox_d ? (10'(dy * SPRITE_W) + col) : 10'd0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_q  <= '0;
            inbox_q <= 1'b0;
            state_q <= ST_STAND;
        end else begin
            addr_q  <= addr_d;
            inbox_q <= inbox_d;
            state_q <= state_i;
        end
    end

    assign addr_o  = addr_q;
    assign inbox_o = inbox_q;
    assign state_o = state_q;
endmodule

// File: rtl/mario_anim_ctrl.sv
// Small-Mario animation FSM plus the two-stage sprite ROM addressing pipeline.
module mario_anim_ctrl
    import mario_pkg::*;
#(
    parameter int SPRITE_W    = SPRITE_W_DEF,
    parameter int SPRITE_H    = SPRITE_H_DEF,
    parameter int WALK_PERIOD = WALK_PERIOD_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [9:0] vel_x,
    input  logic       on_ground,
    input  logic       facing_left,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] MarioX,
    input  logic [9:0] MarioY,
    output logic [9:0] read_address,
    output logic [2:0] frame_sel,
    output logic       pix_valid,
    output logic [2:0] anim_state
);
    localparam int CNT_W = (WALK_PERIOD > 1) ? $clog2(WALK_PERIOD) : 1;

    anim_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_inbox;
    logic [2:0]       s1_state;
    logic             pix_valid_q;
    logic [2:0]       frame_sel_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_STAND;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (frame_tick) begin
            if (!on_ground) begin
                state_d = ST_JUMP;
                cnt_d   = '0;
            end else if (vel_x == 10'd0) begin
                state_d = ST_STAND;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    ST_WALK1, ST_WALK2, ST_WALK3: begin
                        if (cnt_q == CNT_W'(WALK_PERIOD - 1)) begin
                            cnt_d = '0;
                            case (state_q)
                                ST_WALK1: state_d = ST_WALK2;
                                ST_WALK2: state_d = ST_WALK3;
                                default:  state_d = ST_WALK1;
                            endcase
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_WALK1;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    // Stage 1 samples the pre-tick state, so each pixel keeps the frame it was issued in.
    sprite_addr_gen #(
        .SPRITE_W(SPRITE_W),
        .SPRITE_H(SPRITE_H)
    ) u_addr (
        .Clk        (Clk),
        .Reset      (Reset),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .MarioX     (MarioX),
        .MarioY     (MarioY),
        .facing_left(facing_left),
        .state_i    (state_q),
        .addr_o     (read_address),
        .inbox_o    (s1_inbox),
        .state_o    (s1_state)
    );

    // Stage 2 lines up with the ROM's registered read.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix_valid_q <= 1'b0;
            frame_sel_q <= ST_STAND;
        end else begin
            pix_valid_q <= s1_inbox;
            frame_sel_q <= s1_state;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign frame_sel  = frame_sel_q;
    assign anim_state = state_q;
endmodule

// File: tb/tb_mario_anim_ctrl.sv
// Randomized and directed checks of mario_anim_ctrl against a streak-count reference model.
module tb_mario_anim_ctrl;
    localparam int W  = 24;
    localparam int H  = 32;
    localparam int WP = 6;

    logic       Clk = 1'b0;
    logic       Reset, frame_tick, on_ground, facing_left;
    logic [9:0] vel_x, DrawX, DrawY, MarioX, MarioY;
    logic [9:0] read_address;
    logic [2:0] frame_sel, anim_state;
    logic       pix_valid;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: the animation frame follows from how many consecutive
    // moving-on-ground ticks have occurred; pixel tags ride a 2-deep delay.
    int m_n, m_state;
    int e1_addr, e1_vld, e1_st, e2_vld, e2_st;

    mario_anim_ctrl #(.SPRITE_W(W), .SPRITE_H(H), .WALK_PERIOD(WP)) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .vel_x(vel_x),
        .on_ground(on_ground), .facing_left(facing_left),
        .DrawX(DrawX), .DrawY(DrawY), .MarioX(MarioX), .MarioY(MarioY),
        .read_address(read_address), .frame_sel(frame_sel),
        .pix_valid(pix_valid), .anim_state(anim_state)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: predict from the pre-edge inputs, clock, then compare all outputs.
    task automatic cyc();
        int dx, dy, col, inb, addr;
        dx   = (int'(DrawX) - int'(MarioX)) & 1023;
        dy   = (int'(DrawY) - int'(MarioY)) & 1023;
        inb  = (dx < W && dy < H) ? 1 : 0;
        col  = facing_left ? (W - 1 - dx) : dx;
        addr = inb ? (dy * W + col) : 0;
        if (Reset) begin
            m_n = 0; m_state = 0;
            e1_addr = 0; e1_vld = 0; e1_st = 0; e2_vld = 0; e2_st = 0;
        end else begin
            e2_vld = e1_vld; e2_st = e1_st;
            e1_addr = addr; e1_vld = inb; e1_st = m_state;
            if (frame_tick) begin
                if (!on_ground) begin
                    m_n = 0; m_state = 4;
                end else if (vel_x == 10'd0) begin
                    m_n = 0; m_state = 0;
                end else begin
                    m_n++;
                    m_state = 1 + ((m_n - 1) / WP) % 3;
                end
            end
        end
        @(posedge Clk); #1;
        chk("read_address", read_address, e1_addr);
        chk("pix_valid",    pix_valid,    e2_vld);
        chk("frame_sel",    frame_sel,    e2_st);
        chk("anim_state",   anim_state,   m_state);
    endtask

    task automatic tick();
        frame_tick = 1'b1; cyc();
        frame_tick = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; frame_tick = 1'b0; vel_x = '0; on_ground = 1'b1;
        facing_left = 1'b0; DrawX = '0; DrawY = '0; MarioX = 10'd100; MarioY = 10'd50;
        @(negedge Clk);
        cyc(); cyc();
        chk("rst_state", anim_state, 0);
        chk("rst_valid", pix_valid, 0);

        // Standing still
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stand_hold", anim_state, 0);
        end

        // Walk cycle timing
        vel_x = 10'd5;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 1)  chk("walk_t1",  anim_state, 1);
            if (k == 7)  chk("walk_t7",  anim_state, 2);
            if (k == 13) chk("walk_t13", anim_state, 3);
            if (k == 19) chk("walk_t19", anim_state, 1);
        end
        for (int k = 0; k < 6; k++) tick();
        chk("walk2_again", anim_state, 2);
        on_ground = 1'b0; tick();
        chk("jump", anim_state, 4);
        on_ground = 1'b1; vel_x = '0; tick();
        chk("land_stand", anim_state, 0);

        // Addressing examples
        DrawX = 10'd105; DrawY = 10'd52;
        cyc(); chk("addr_right", read_address, 53);
        cyc(); chk("valid_right", pix_valid, 1);
        facing_left = 1'b1;
        cyc(); chk("addr_left", read_address, 66);
        facing_left = 1'b0;
        DrawX = 10'd99;
        cyc(); chk("addr_x99", read_address, 0);
        cyc(); chk("valid_x99", pix_valid, 0);
        DrawX = 10'd124;
        cyc(); chk("addr_x124", read_address, 0);
        cyc(); chk("valid_x124", pix_valid, 0);
        DrawX = 10'd123;
        cyc(); chk("addr_x123", read_address, 2 * W + 23);
        MarioX = 10'd5; DrawX = 10'd2;
        cyc(); chk("addr_wrap", read_address, 0);
        cyc(); chk("valid_wrap", pix_valid, 0);

        // State change while pixels stream
        MarioX = 10'd100; DrawX = 10'd101; vel_x = 10'd3;
        tick();
        DrawX = 10'd102;
        cyc(); chk("tick_pix_sel", frame_sel, 0);
        DrawX = 10'd103;
        cyc(); chk("next_pix_sel", frame_sel, 1);
        Reset = 1'b1;
        cyc(); chk("rst_mid_valid", pix_valid, 0);
        Reset = 1'b0;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            Reset       = ($urandom_range(0, 99) == 0);
            frame_tick  = ($urandom_range(0, 2) == 0);
            vel_x       = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
            on_ground   = ($urandom_range(0, 4) != 0);
            facing_left = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                MarioX = 10'($urandom_range(0, 1023));
                MarioY = 10'($urandom_range(0, 1023));
            end
            DrawX = 10'(int'(MarioX) + $urandom_range(0, 40) - 8);
            DrawY = 10'(int'(MarioY) + $urandom_range(0, 48) - 8);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mario_anim_ctrl.md
MARIO_ANIM_CTRL -- requirements
Module: mario_anim_ctrl

Interface
REQ-001 Parameter SPRITE_W, default 24, sprite width in pixels.
REQ-002 Parameter SPRITE_H, default 32, sprite height in pixels; SPRITE_W*SPRITE_H SHALL be at most 1024.
REQ-003 Parameter WALK_PERIOD, default 6, number of video frames per walk-cycle step.
REQ-004 Clk  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 frame_tick  in  1  one-cycle pulse per video frame, asserted at vertical sync.
REQ-007 vel_x  in  10  signed horizontal velocity; only zero and non-zero are significant.
REQ-008 on_ground  in  1  high when Mario stands on a surface.
REQ-009 facing_left  in  1  high selects horizontally mirrored sprite.
REQ-010 DrawX, DrawY  in  10 each  current pixel coordinate from the VGA controller.
REQ-011 MarioX, MarioY  in  10 each  sprite top-left position.
REQ-012 read_address  out  10  address driven to every small-Mario sprite ROM.
REQ-013 frame_sel  out  3  animation frame whose ROM output is selected, aligned with ROM data.
REQ-014 pix_valid  out  1  high when the ROM data of this cycle belongs to a pixel inside the sprite box.
REQ-015 anim_state  out  3  current animation state, for debug.

Function
REQ-016 States: STAND, WALK1, WALK2, WALK3, JUMP; state and walk counter SHALL change only in cycles where frame_tick=1.
REQ-017 On frame_tick, on_ground=0 SHALL force JUMP from any state; the walk counter clears.
REQ-018 On frame_tick with on_ground=1 and vel_x=0, next state SHALL be STAND; the walk counter clears.
REQ-019 On frame_tick with on_ground=1 and vel_x!=0: STAND or JUMP SHALL go to WALK1 with the counter cleared; in WALK states the counter increments, and when it reaches WALK_PERIOD-1 it clears and the state advances WALK1->WALK2->WALK3->WALK1.
REQ-020 dx=DrawX-MarioX and dy=DrawY-MarioY SHALL be computed modulo 2^10, so that negative differences fall outside the box.
REQ-021 The pixel SHALL be in-box when dx<SPRITE_W and dy<SPRITE_H.
REQ-022 col SHALL be SPRITE_W-1-dx when facing_left=1, else dx; address SHALL be dy*SPRITE_W+col, maximum 767 at default parameters.
REQ-023 Pipeline stage 1: on edge k, read_address SHALL register the address, or 0 when the pixel is out of box. In the same stage, in-box and anim_state SHALL be registered as pipeline tags.
REQ-024 Pipeline stage 2: on edge k+1, concurrent with the ROM's registered read, pix_valid and frame_sel SHALL register the stage-1 tags; total latency from DrawX/DrawY to pix_valid and frame_sel SHALL be 2 cycles.
REQ-025 A state change in the same cycle as a pixel SHALL NOT corrupt in-flight pixels; each pixel SHALL carry the frame_sel captured at its stage 1.
REQ-026 frame_sel encoding SHALL equal the anim_state encoding: STAND=0, WALK1=1, WALK2=2, WALK3=3, JUMP=4.

Reset
REQ-027 While Reset=1 on a rising edge, the block SHALL set anim_state=STAND, the walk counter to 0, read_address=0, frame_sel=0 and pix_valid=0, and SHALL flush all pipeline tags.
REQ-028 Reset SHALL take priority over a simultaneous frame_tick.
REQ-029 After reset deasserts, the first valid pix_valid SHALL appear no earlier than 2 cycles later.

Structure
REQ-030 Package mario_pkg SHALL hold the anim_state_e enum (3 bits) and the defaults for SPRITE_W, SPRITE_H and WALK_PERIOD.
REQ-031 The address and in-box computation with stage-1 registers SHALL be the sub-module sprite_addr_gen; the FSM, the walk counter and stage 2 SHALL reside in mario_anim_ctrl.
REQ-032 The design SHALL NOT use multipliers other than a constant multiply by SPRITE_W.

Verification
REQ-033 Scenario: Reset, then on_ground=1, vel_x=0, and 3 frame_ticks -> the bench SHALL see anim_state=STAND throughout.
REQ-034 Scenario: vel_x=5, on_ground=1, and 19 frame_ticks -> the bench SHALL see WALK1 after tick 1, WALK2 after tick 7, WALK3 after tick 13 and WALK1 after tick 19.
REQ-035 Scenario: on_ground dropped to 0 while in WALK2, then one tick -> JUMP; on_ground=1 with vel_x=0 and one more tick -> STAND.
REQ-036 Scenario: MarioX=100, MarioY=50, DrawX=105, DrawY=52, facing_left=0 -> read_address=53 after 1 cycle and pix_valid=1 after 2 cycles. The same pixel with facing_left=1 -> read_address=66.
REQ-037 Scenario: DrawX=99 or DrawX=124 with DrawY=52, and MarioX=5 with DrawX=2 -> read_address=0 and pix_valid=0.
REQ-038 Scenario: frame_tick changes the state STAND->WALK1 while back-to-back pixels stream -> the pixel issued in the tick cycle carries frame_sel=0 and the next pixel carries frame_sel=1; Reset asserted mid-stream -> pix_valid=0 on the following edge.
